// File: rtl/accum_feeder_pkg.sv
// ---------------------------------------------------------------------------
// accum_feeder_pkg
// Shared types and constants for the accumulator feeder.
//   state_t      : issue FSM states (IDLE, ISSUE, HOLD)
//   HOLD_MIN     : minimum enable spacing the accumulator tolerates
//   LED_LSB/MSB  : slice of the accumulator count shown on its led port
// ---------------------------------------------------------------------------
package accum_feeder_pkg;

    // The accumulator samples enable, adds two cycles later, and is ready again
    // on the third cycle, so pulses closer than this would be lost.
    localparam int unsigned HOLD_MIN = 3;

    // led[7:0] of the accumulator is count[23:16].
    localparam int unsigned LED_LSB = 16;
    localparam int unsigned LED_MSB = 23;
    localparam int unsigned LED_W   = LED_MSB - LED_LSB + 1;

    // Width of the issued-word counter.
    localparam int unsigned ISSUE_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage : accum_feeder_pkg

// File: rtl/accum_feeder_fifo.sv
// ---------------------------------------------------------------------------
// accum_feeder_fifo
// Pointer-based synchronous FIFO. The head word is read combinationally from
// the registered read pointer (no fall-through from the write side).
//   CLK, RST_N : clock, asynchronous active-low reset
//   i_push     : write request (ignored while full)
//   i_data     : write data
//   i_pop      : read request (ignored while empty)
//   o_head     : word at the read pointer
//   o_full     : FIFO holds DEPTH words
//   o_empty    : FIFO holds no words
// ---------------------------------------------------------------------------
module accum_feeder_fifo #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_head,
    output logic              o_full,
    output logic              o_empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    // Pointers wrap by natural overflow, which needs a power-of-two depth.
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_chk
        $error("accum_feeder_fifo: DEPTH must be a power of 2 and >= 2");
    end

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic w_push_ok;
    logic w_pop_ok;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_head    = r_mem[r_rd_ptr];
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;

    // Storage array carries no reset; only pointers define validity.
    always_ff @(posedge CLK) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy update; simultaneous push/pop leaves count unchanged.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : accum_feeder_fifo

// File: rtl/accum_feeder.sv
// ---------------------------------------------------------------------------
// accum_feeder
// Buffers upstream words and issues them to the enable/value accumulator as
// paced one-cycle enable pulses, holding value steady while the add is
// pending. A shadow sum tracks what the accumulator's count should be.
//   CLK, RST_N  : clock, asynchronous active-low reset
//   in_valid    : upstream word valid
//   in_data     : upstream word
//   in_ready    : FIFO not full (decoded, not registered)
//   pause       : blocks new issues; an in-flight issue completes
//   enable      : one-cycle pulse to the accumulator
//   value       : word being issued, held between issues
//   busy        : issue in progress (ISSUE or HOLD)
//   shadow_sum  : modelled accumulator count
//   led_exp     : shadow_sum[23:16], expected accumulator led
//   issued_cnt  : words issued, modulo 2^16
// ---------------------------------------------------------------------------
module accum_feeder
    import accum_feeder_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned SPACING = 3
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   in_valid,
    input  logic [DATA_W-1:0]      in_data,
    output logic                   in_ready,
    input  logic                   pause,
    output logic                   enable,
    output logic [DATA_W-1:0]      value,
    output logic                   busy,
    output logic [DATA_W-1:0]      shadow_sum,
    output logic [LED_W-1:0]       led_exp,
    output logic [ISSUE_CNT_W-1:0] issued_cnt
);

    if (SPACING < HOLD_MIN) begin : g_spacing_chk
        $error("accum_feeder: SPACING must be >= HOLD_MIN");
    end

    if (DATA_W <= LED_MSB) begin : g_width_chk
        $error("accum_feeder: DATA_W must cover the led slice");
    end

    localparam int unsigned HOLD_W = $clog2(SPACING);

    // HOLD lasts SPACING-1 cycles: counter runs SPACING-2 down to 0.
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(SPACING - 2);
    // The accumulator adds at the edge ending the second cycle after enable,
    // which is the HOLD cycle whose counter reads SPACING-3.
    localparam logic [HOLD_W-1:0] ADD_AT    = HOLD_W'(SPACING - HOLD_MIN);

    state_t                 r_state;
    logic [HOLD_W-1:0]      r_hold_cnt;
    logic                   r_enable;
    logic                   r_busy;
    logic [DATA_W-1:0]      r_value;
    logic [DATA_W-1:0]      r_shadow_sum;
    logic [LED_W-1:0]       r_led_exp;
    logic [ISSUE_CNT_W-1:0] r_issued_cnt;

    logic [DATA_W-1:0]      w_fifo_head;
    logic                   w_fifo_full;
    logic                   w_fifo_empty;
    logic                   w_start;
    logic [DATA_W-1:0]      w_sum_next;

    // Input buffer.
    accum_feeder_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .i_push  (in_valid),
        .i_data  (in_data),
        .i_pop   (w_start),
        .o_head  (w_fifo_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign in_ready   = !w_fifo_full;
    assign w_start    = (r_state == IDLE) && !w_fifo_empty && !pause;
    assign w_sum_next = r_shadow_sum + r_value;

    // Issue FSM, pacing counter and shadow accumulator.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state      <= IDLE;
            r_hold_cnt   <= '0;
            r_enable     <= 1'b0;
            r_busy       <= 1'b0;
            r_value      <= '0;
            r_shadow_sum <= '0;
            r_led_exp    <= '0;
            r_issued_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_value  <= w_fifo_head;
                        r_enable <= 1'b1;
                        r_busy   <= 1'b1;
                        r_state  <= ISSUE;
                    end
                end

                ISSUE: begin
                    r_enable   <= 1'b0;
                    r_hold_cnt <= HOLD_INIT;
                    r_state    <= HOLD;
                end

                HOLD: begin
                    // Mirror the accumulator's add on the same edge it happens.
                    if (r_hold_cnt == ADD_AT) begin
                        r_shadow_sum <= w_sum_next;
                        r_led_exp    <= w_sum_next[LED_MSB:LED_LSB];
                        r_issued_cnt <= r_issued_cnt + ISSUE_CNT_W'(1);
                    end
                    if (r_hold_cnt == '0) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
                    end
                end

                default: begin
                    r_enable <= 1'b0;
                    r_busy   <= 1'b0;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

    assign enable     = r_enable;
    assign busy       = r_busy;
    assign value      = r_value;
    assign shadow_sum = r_shadow_sum;
    assign led_exp    = r_led_exp;
    assign issued_cnt = r_issued_cnt;

endmodule : accum_feeder

// File: tb/tb_accum_feeder.sv
// ---------------------------------------------------------------------------
// tb_accum_feeder
// Scoreboard bench: accepted words are queued as they enter; a negedge monitor
// pops them as enable pulses appear and checks value, pacing, busy, in_ready
// and the delayed shadow-sum commit. A small behavioural accumulator provides
// the reference led.
// ---------------------------------------------------------------------------
module tb_accum_feeder;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned SPACING = 3;

    logic              CLK      = 1'b0;
    logic              RST_N    = 1'b0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data  = '0;
    logic              pause    = 1'b0;
    logic              in_ready;
    logic              enable;
    logic [DATA_W-1:0] value;
    logic              busy;
    logic [DATA_W-1:0] shadow_sum;
    logic [7:0]        led_exp;
    logic [15:0]       issued_cnt;

    accum_feeder #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .SPACING (SPACING)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .pause      (pause),
        .enable     (enable),
        .value      (value),
        .busy       (busy),
        .shadow_sum (shadow_sum),
        .led_exp    (led_exp),
        .issued_cnt (issued_cnt)
    );

    always #5 CLK = ~CLK;

    int n_pass = 0;
    int n_tot  = 0;
    int cyc    = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference accumulator: sync active-high reset, adds value two cycles
    // after it samples enable, accepts a new enable once idle again.
    logic [31:0] acc_cnt  = '0;
    int          acc_pend = 0;
    always @(posedge CLK) begin
        if (!RST_N) begin
            acc_cnt  <= '0;
            acc_pend <= 0;
        end else if (acc_pend == 0) begin
            if (enable) acc_pend <= 2;
        end else begin
            acc_pend <= acc_pend - 1;
            if (acc_pend == 1) acc_cnt <= acc_cnt + value;
        end
    end

    // Scoreboard state.
    typedef struct {
        int          due;
        logic [31:0] sum;
        logic [15:0] cnt;
    } commit_t;

    logic [31:0] q[$];          // words accepted but not yet issued
    commit_t     chk_q[$];      // pending shadow-sum commits
    int          en_log[$];     // cycles on which enable was seen
    logic [31:0] m_sum     = '0;
    logic [31:0] m_commit  = '0;
    logic [15:0] m_cnt     = '0;
    logic [15:0] m_ccnt    = '0;
    logic [31:0] m_last    = '0;
    logic [31:0] w_exp;
    int          last_en   = -1000;
    logic        prev_en   = 1'b0;

    // Monitor: everything observed at the falling edge.
    always @(negedge CLK) begin
        if (!RST_N) begin
            q.delete();
            chk_q.delete();
            m_sum    = '0;
            m_commit = '0;
            m_cnt    = '0;
            m_ccnt   = '0;
            m_last   = '0;
            last_en  = -1000;
            prev_en  = 1'b0;
        end else begin
            if (enable) begin
                chk("no_back_to_back", 32'(prev_en), 32'd0);
                n_tot++;
                if (cyc - last_en >= int'(SPACING) + 1) n_pass++;
                else $display("FAIL enable_spacing: got %0d cycles required >= %0d", cyc - last_en, SPACING + 1);
                if (q.size() == 0) begin
                    chk("spurious_enable", 32'd1, 32'd0);
                end else begin
                    w_exp = q.pop_front();
                    chk("issue_value", value, w_exp);
                    m_last = w_exp;
                    m_sum  = m_sum + w_exp;
                    m_cnt  = m_cnt + 16'd1;
                    chk_q.push_back('{cyc + 3, m_sum, m_cnt});
                end
                last_en = cyc;
                en_log.push_back(cyc);
            end else begin
                chk("value_hold", value, m_last);
            end
            if (chk_q.size() > 0 && chk_q[0].due == cyc) begin
                m_commit = chk_q[0].sum;
                m_ccnt   = chk_q[0].cnt;
                void'(chk_q.pop_front());
            end
            chk("shadow_sum", shadow_sum, m_commit);
            chk("led_exp", 32'(led_exp), 32'(m_commit[23:16]));
            chk("issued_cnt", 32'(issued_cnt), 32'(m_ccnt));
            chk("busy", 32'(busy), 32'((cyc - last_en) < int'(SPACING)));
            chk("in_ready", 32'(in_ready), 32'(q.size() < int'(DEPTH)));
            chk("acc_led_match", 32'(led_exp), 32'(acc_cnt[23:16]));
            if (in_valid && in_ready) q.push_back(in_data);
            prev_en = enable;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Offer one word and hold it until accepted.
    task automatic push(input logic [31:0] w);
        bit ok = 0;
        in_valid = 1'b1;
        in_data  = w;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if (in_ready) begin ok = 1; break; end
        end
        if (!ok) chk("push_timeout", 32'd1, 32'd0);
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_enable();
        bit ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (enable) begin ok = 1; break; end
        end
        if (!ok) chk("enable_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_drain();
        bit ok = 0;
        for (int i = 0; i < 400; i++) begin
            if (q.size() == 0 && !busy && chk_q.size() == 0) begin ok = 1; break; end
            tick();
        end
        if (!ok) chk("drain_timeout", 32'd1, 32'd0);
        tick();
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        pause    = 1'b0;
        RST_N    = 1'b0;
        repeat (2) tick();
        RST_N = 1'b1;
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [31:0] w1, w2, w3, w4, w5;

    initial begin
        // Reset state.
        RST_N = 1'b0;
        repeat (3) tick();
        chk("rst_enable", 32'(enable), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_value", value, 32'd0);
        chk("rst_shadow", shadow_sum, 32'd0);
        chk("rst_led", 32'(led_exp), 32'd0);
        chk("rst_issued", 32'(issued_cnt), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        RST_N = 1'b1;

        // Single word.
        tick();
        push(32'h0001_0000);
        wait_drain();
        chk("single_shadow", shadow_sum, 32'h0001_0000);
        chk("single_led", 32'(led_exp), 32'h01);
        chk("single_issued", 32'(issued_cnt), 32'd1);

        // Burst of four while paused, then release.
        do_reset();
        pause = 1'b1;
        push(32'h0001_0000);
        push(32'h0002_0000);
        push(32'h0003_0000);
        push(32'h0004_0000);
        chk("full_in_ready_low", 32'(in_ready), 32'd0);
        en_log.delete();
        repeat (6) tick();
        chk("paused_no_enable", 32'(en_log.size()), 32'd0);
        pause = 1'b0;
        tick();
        chk("resume_within_1", 32'(enable), 32'd1);
        wait_drain();
        chk("burst_pulses", 32'(en_log.size()), 32'd4);
        for (int i = 1; i < en_log.size(); i++)
            chk("burst_gap", 32'(en_log[i] - en_log[i-1]), 32'(SPACING + 1));
        chk("burst_shadow", shadow_sum, 32'h000A_0000);
        chk("burst_led", 32'(led_exp), 32'h0A);

        // Pause asserted during HOLD: the in-flight add still lands.
        do_reset();
        w1 = 32'h0003_0000;
        w2 = 32'h0000_0700;
        push(w1);
        push(w2);
        wait_enable();
        tick();
        pause = 1'b1;
        en_log.delete();
        repeat (8) tick();
        chk("pause_hold_shadow", shadow_sum, w1);
        chk("pause_hold_issued", 32'(issued_cnt), 32'd1);
        chk("pause_hold_no_issue", 32'(en_log.size()), 32'd0);
        pause = 1'b0;
        wait_drain();
        chk("pause_hold_final", shadow_sum, w1 + w2);

        // Wrap-around of the sum.
        do_reset();
        push(32'hFFFF_FFFF);
        push(32'h0000_0002);
        wait_drain();
        chk("wrap_shadow", shadow_sum, 32'h0000_0001);
        chk("wrap_led", 32'(led_exp), 32'h00);
        chk("wrap_issued", 32'(issued_cnt), 32'd2);

        // Reset during HOLD aborts the issue and drops queued words.
        do_reset();
        push(32'h0055_0000);
        push(32'h0066_0000);
        wait_enable();
        @(posedge CLK);
        #2;
        RST_N = 1'b0;
        #1;
        chk("midrst_enable", 32'(enable), 32'd0);
        chk("midrst_value", value, 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_shadow", shadow_sum, 32'd0);
        chk("midrst_issued", 32'(issued_cnt), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        repeat (2) tick();
        RST_N = 1'b1;
        en_log.delete();
        repeat (12) tick();
        chk("midrst_no_reissue", 32'(en_log.size()), 32'd0);
        chk("midrst_shadow_after", shadow_sum, 32'd0);

        // Push on the pop edge with three words queued.
        do_reset();
        w1 = $urandom; w2 = $urandom; w3 = $urandom; w4 = $urandom; w5 = $urandom;
        pause = 1'b1;
        push(w1);
        push(w2);
        push(w3);
        in_valid = 1'b1;
        in_data  = w4;
        pause    = 1'b0;
        @(negedge CLK);
        chk("pp_ready_at3", 32'(in_ready), 32'd1);
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        chk("pp_enable", 32'(enable), 32'd1);
        chk("pp_still_3", 32'(in_ready), 32'd1);
        push(w5);
        chk("pp_then_full", 32'(in_ready), 32'd0);
        wait_drain();
        chk("pp_shadow", shadow_sum, w1 + w2 + w3 + w4 + w5);

        // Randomized traffic with sporadic pause.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = $urandom;
            pause    = ($urandom_range(0, 7) == 0);
            tick();
        end
        in_valid = 1'b0;
        pause    = 1'b0;
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule : tb_accum_feeder

// File: doc/accum_feeder.md
Name: accum_feeder

Overview:
- Transmit-side driver for the team's 3-state enable/value accumulator, whose port contract is CLK, active-high sync RST, enable, value[31:0] and led[7:0] = count[23:16].
  - The accumulator samples enable in its idle state.
  - It adds value two cycles later.
  - It can accept a new enable again on the third cycle.
- accum_feeder buffers words from an upstream valid/ready source and issues them as paced enable pulses, holding value stable while the accumulator's add is pending.
- It keeps a shadow sum so the bench or higher level can check the accumulator's led output.

Parameters:
- DATA_W, 32, width of data words, value and shadow sum.
- DEPTH, 4, input FIFO entries (power of 2, ≥2).
- SPACING, 3, cycles between successive enable pulses. Must be ≥ HOLD_MIN (3); elaboration error otherwise.

Ports:
- CLK  in  1  clock.
- RST_N  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream word valid.
- in_data  in  DATA_W  upstream word.
- in_ready  out  1  FIFO can accept; equals !full.
- pause  in  1  when high, no new issue starts; an in-flight issue completes.
- enable  out  1  one-cycle pulse to the accumulator.
- value  out  DATA_W  word being issued, held stable.
- busy  out  1  high in ISSUE or HOLD.
- shadow_sum  out  DATA_W  modelled accumulator count.
- led_exp  out  8  shadow_sum[23:16].
- issued_cnt  out  16  number of words issued, wraps modulo 2^16.

Behaviour:
- Reset (RST_N low, asynchronous, takes effect without a clock edge):
  - FIFO empties.
  - FSM goes to IDLE.
  - enable, busy, value, shadow_sum, led_exp and issued_cnt are 0.
  - in_ready is 1.
  - Reset asserted mid-HOLD aborts the issue: enable is low immediately and no sum update occurs.
- All outputs are registered, except in_ready, which is decoded from FIFO count.
- FIFO:
  - Push when in_valid && in_ready.
  - Pop only on the IDLE→ISSUE transition.
  - Push and pop in the same cycle are both allowed; count is unchanged.
  - When full, in_ready=0 and in_data is ignored.
  - First-word fall-through is not required; the head is read from a registered read pointer.
- FSM states: IDLE, ISSUE, HOLD.
  - IDLE: if FIFO is non-empty and pause=0, then at the edge:
    - value <= head; enable <= 1; pop; busy <= 1; go to ISSUE.
    - Otherwise enable stays 0 and value keeps its last word.
  - ISSUE (cycle t, enable=1): at the edge, enable <= 0, hold counter <= SPACING-2, go to HOLD.
  - HOLD: value is unchanged. Decrement the counter. When the counter is 0, at the edge go to IDLE with busy <= 0.
    - With SPACING=3: enable is high in cycle t, HOLD occupies t+1..t+2, IDLE is reached in t+3.
    - The next enable is therefore earliest at t+4 (registered issue), which is ≥ the accumulator's required t+3.
  - pause has no effect in ISSUE or HOLD.
- Shadow sum:
  - At the edge ending cycle t+2 of each issue: shadow_sum <= shadow_sum + value, modulo 2^DATA_W, wrap with no flag.
  - issued_cnt increments on the same edge.
  - This matches the accumulator's count after the same edge.
  - led_exp is registered from the updated sum.
- value is guaranteed stable from cycle t through at least t+SPACING-1.
- enable is never high for two consecutive cycles.

Decomposition:
- Package accum_feeder_pkg:
  - state enum {IDLE, ISSUE, HOLD}.
  - HOLD_MIN = 3.
  - LED_LSB = 16, LED_MSB = 23.
- Sub-module accum_feeder_fifo (DATA_W, DEPTH):
  - Pointer FIFO with count, full/empty, and push/pop handling.
  - Async active-low reset on the same CLK/RST_N.
- The FSM, pacing counter and shadow sum live in the top.

Test Plan:
- Reset then single word: push 0x0001_0000 at cycle 2 →
  - enable pulses once.
  - value=0x0001_0000 holds 3 cycles.
  - shadow_sum=0x0001_0000 and led_exp=0x01 after t+2.
  - issued_cnt=1.
- Burst of 4 (fill FIFO): 0x10000, 0x20000, 0x30000, 0x40000 back-to-back →
  - in_ready drops when full.
  - enable pulses are exactly 4 cycles apart.
  - Final shadow_sum=0xA0000, led_exp=0x0A.
  - The connected accumulator's led matches led_exp each cycle.
- Pause: hold pause=1 with 2 words queued → no enable. Release → issues resume within 1 cycle. Assert pause during HOLD → the current issue completes its sum update.
- Wrap-around: preload via 0xFFFF_FFFF then 0x2 → shadow_sum=0x0000_0001, led_exp=0x00, no error.
- Reset mid-HOLD: drop RST_N one cycle after enable →
  - enable=0 and value=0 asynchronously.
  - shadow_sum=0 and issued_cnt=0.
  - After release, a queued-before-reset word is not issued.
- Simultaneous push/pop at count 3: push on the pop edge → count stays 3 and the order is preserved (check value sequence).
